// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front-end: access size encodings,
// controller state names and the default top of the legal address range.
package mem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   localparam logic [31:0] ADDR_MAX_DEFAULT = 32'h0000007c;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   // Word-aligned form of a byte address, as presented to the memory port.
   function automatic logic [31:0] wordAddr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane steering between a memory word and sub-word data.
// The extract path picks the addressed byte/half out of a read word and
// extends it; the merge path drops store data into the addressed lane of a
// read word so the whole word can be written back.
module lane_align
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_lane,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [4:0]  w_byteOff;
   logic [4:0]  w_halfOff;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byteOff = {i_lane, 3'b000};
   assign w_halfOff = {i_lane[1], 4'b0000};

   // Pick the addressed lane and extend it to a full load result.
   always_comb begin
      w_byte = i_word[w_byteOff +: 8];
      w_half = i_word[w_halfOff +: 16];
      o_load = i_word;
      case (i_size)
         SIZE_B:  o_load = {{24{i_signed & w_byte[7]}}, w_byte};
         SIZE_H:  o_load = {{16{i_signed & w_half[15]}}, w_half};
         default: o_load = i_word;
      endcase
   end

   // Overlay the right-justified store data onto the addressed lane.
   always_comb begin
      o_merge = i_word;
      case (i_size)
         SIZE_B:  o_merge[w_byteOff +: 8]  = i_wdata[7:0];
         SIZE_H:  o_merge[w_halfOff +: 16] = i_wdata[15:0];
         default: o_merge = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end between execute and data memory. Takes one request
// at a time, runs a READ and/or WRITE cycle on the word-wide memory port
// (read-modify-write for byte/half stores) and returns a one-cycle response.
// Faulting requests never touch memory.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter logic [31:0] ADDR_MAX = ADDR_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [31:0] mem_a,
   output logic [31:0] mem_di,
   output logic        mem_we,
   input  logic [31:0] mem_do
);

   state_t      r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_reqReady;
   logic        r_rspValid;
   logic [31:0] r_rspData;
   logic        r_rspFault;
   logic [31:0] r_memDi;
   logic        r_memWe;

   logic        w_fault;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   // Reject illegal sizes, misaligned half/word accesses and anything whose
   // word lies past the top of the legal range.
   always_comb begin
      w_fault = 1'b0;
      if (req_size == SIZE_X)
         w_fault = 1'b1;
      if ((req_size == SIZE_H) && req_addr[0])
         w_fault = 1'b1;
      if ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00))
         w_fault = 1'b1;
      if (wordAddr(req_addr) > ADDR_MAX)
         w_fault = 1'b1;
   end

   lane_align u_laneAlign (
      .i_word   (mem_do),
      .i_wdata  (r_wdata),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_lane   (r_addr[1:0]),
      .o_load   (w_load),
      .o_merge  (w_merge)
   );

   // Request controller: latch the request, sequence READ/WRITE on the memory
   // port and produce the response, with every output held in a register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_we       <= 1'b0;
         r_size     <= SIZE_B;
         r_signed   <= 1'b0;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_reqReady <= 1'b1;
         r_rspValid <= 1'b0;
         r_rspData  <= 32'h0;
         r_rspFault <= 1'b0;
         r_memDi    <= 32'h0;
         r_memWe    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_signed   <= req_signed;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_reqReady <= 1'b0;
                  r_rspData  <= 32'h0;
                  if (w_fault) begin
                     r_rspFault <= 1'b1;
                     r_rspValid <= 1'b1;
                     r_state    <= ST_RESP;
                  end else if (req_we && (req_size == SIZE_W)) begin
                     r_memDi <= req_wdata;
                     r_memWe <= 1'b1;
                     r_state <= ST_WRITE;
                  end else begin
                     r_state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (r_we) begin
                  r_memDi <= w_merge;
                  r_memWe <= 1'b1;
                  r_state <= ST_WRITE;
               end else begin
                  r_rspData  <= w_load;
                  r_rspValid <= 1'b1;
                  r_state    <= ST_RESP;
               end
            end
            ST_WRITE: begin
               r_memDi    <= 32'h0;
               r_memWe    <= 1'b0;
               r_rspValid <= 1'b1;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               r_rspValid <= 1'b0;
               r_rspData  <= 32'h0;
               r_rspFault <= 1'b0;
               r_reqReady <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_memWe    <= 1'b0;
               r_memDi    <= 32'h0;
               r_rspValid <= 1'b0;
               r_reqReady <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_reqReady;
   assign rsp_valid = r_rspValid;
   assign rsp_rdata = r_rspData;
   assign rsp_fault = r_rspFault;
   assign mem_a     = wordAddr(r_addr);
   assign mem_di    = r_memDi;
   assign mem_we    = r_memWe;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end between the execute stage and `data_memory`. Accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. Drives the word-wide memory port (aligned address, write data, write enable) and performs read-modify-write for sub-word stores. Returns sign- or zero-extended load data, or a fault for misaligned or out-of-range addresses.

## Interface
Parameters:
- `ADDR_MAX`, default 32'h0000007c: highest legal word-aligned address. Any access with an address above this faults.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load data. Ignored for word accesses and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: load result. 0 for stores and faults.
- `rsp_fault` out 1: request rejected; memory untouched.
- `mem_a` out 32: word-aligned address to memory, `{addr[31:2],2'b00}`.
- `mem_di` out 32: write data to memory.
- `mem_we` out 1: memory write enable.
- `mem_do` in 32: memory read data (combinational from `mem_a`).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid` the unit latches `req_we`, `req_size`, `req_signed`, `req_addr` and `req_wdata`, then moves on:
  - Fault (size 11; half with `addr[0]`≠0; word with `addr[1:0]`≠0; aligned address > `ADDR_MAX`) → RESP with the fault flag set.
  - Word store → WRITE.
  - Any other request → READ.
- READ: drive `mem_a`, with `mem_we`=0, and capture `mem_do` into a data register.
  - Load → RESP.
  - Sub-word store → WRITE.
- WRITE: drive `mem_a`, `mem_di` and `mem_we`=1 for exactly one cycle, then → RESP.
  - Word store: `mem_di` = `wdata`.
  - Byte store: `mem_di` = captured word with lane `addr[1:0]` replaced by `wdata[7:0]`.
  - Half store: `mem_di` = captured word with lane `addr[1]` replaced by `wdata[15:0]`.
- RESP: `rsp_valid`=1 for one cycle, then → IDLE.
- Load data extraction (little-endian lanes):
  - Byte: lane `addr[1:0]`.
  - Half: lane `addr[1]`.
  - Word: whole word.
  - Extension: sign-extend if `req_signed`, otherwise zero-extend.
- Responses have no backpressure. The consumer must take `rsp_*` in the RESP cycle.
- `mem_a` holds the latched aligned address outside READ/WRITE (0 after reset). `mem_di` is 0 when not in WRITE.

## Timing
- Reset values:
  - State IDLE; `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0.
  - `mem_a`=0, `mem_di`=0, `mem_we`=0.
- Request accepted at edge T0 (IDLE, `req_valid`=1). Latencies to `rsp_valid`:
  - Load: READ in T1, RESP in T2 → 2 cycles.
  - Word store: WRITE in T1, RESP in T2 → 2 cycles.
  - Sub-word store: READ T1, WRITE T2, RESP T3 → 3 cycles.
  - Fault: RESP in T1 → 1 cycle. `mem_we` never asserted.
- `req_ready`=0 in every non-IDLE state. A new request can be accepted in the cycle after RESP. Peak throughput is one request per 3 cycles (loads, word stores).
- `mem_we` is asserted only in WRITE and never for 2 consecutive cycles.
- `req_valid` held high during RESP is not accepted until IDLE.
- Reset asserted in any state:
  - All outputs return to reset values immediately (asynchronously).
  - An in-flight store whose WRITE cycle has not completed leaves memory unchanged.
  - No response is emitted.

## Structure
- Shared package `mem_pkg`:
  - Size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`.
  - State enum.
  - `ADDR_MAX` default.
- Sub-module `lane_align`: combinational.
  - Extract/extend path: input word, size, signed flag, `addr[1:0]` → load result.
  - Merge path: input word, store data, size, `addr[1:0]` → merged write word.
- Top level holds the FSM and the request/data registers.

## Test plan
- Memory preloaded with 0x50=0x000000a3.
  - Signed lb 0x50 → `rsp_rdata`=0xffffffa3 at T2.
  - Unsigned lb 0x50 → 0x000000a3.
- sb 0x51, wdata 0x5a → READ then WRITE with `mem_a`=0x50, `mem_di`=0x00005aa3, `mem_we`=1 for one cycle; `rsp_valid` at T3. A following lw 0x50 → 0x00005aa3.
- sh 0x52, wdata 0x1234 → word 0x50 becomes 0x12345aa3. Signed lh 0x52 → 0x00001234.
- sw 0x54, wdata 0xdeadbeef → `mem_we` pulse in T1 with no READ cycle; `rsp_valid` at T2.
- Faults, each giving `rsp_fault`=1 at T1 with `mem_we` never high:
  - lw 0x52.
  - lh 0x51.
  - size 11.
  - lw 0x80 (above `ADDR_MAX`).
- Reset mid-operation: start sb 0x58 and assert `reset` during WRITE.
  - `mem_we` drops immediately; no `rsp_valid`.
  - `req_ready`=1 after release.
  - Word 0x58 keeps its preloaded value.
